// File: rtl/blockmem_2p_pkg.sv
`default_nettype none
// ============================================================================
// Module : blockmem_2p_pkg
// Shared FSM encoding and read-credit depth for the port-B stream reader.
// Rev    : 1.0
// ============================================================================
package blockmem_2p_pkg;

  // Reads outstanding (buffered + in flight) never exceed this.
  localparam int c_credit_depth = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/blockmem_2p_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module : blockmem_2p_stream_reader_if
// Command, memory port B and AXI-stream signals of the stream reader.
// Rev    : 1.0
// ============================================================================
interface blockmem_2p_stream_reader_if #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024
);
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [G_ADDRWIDTH-1:0] cmd_addr;
  logic [G_ADDRWIDTH:0]   cmd_len;
  logic                   enb;
  logic [G_ADDRWIDTH-1:0] addrb;
  logic [G_DATAWIDTH-1:0] doutb;
  logic [G_DATAWIDTH-1:0] m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic                   busy;
  logic                   done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, doutb, m_axis_tready,
    output cmd_ready, enb, addrb, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, doutb, m_axis_tready,
    input  cmd_ready, enb, addrb, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/blockmem_2p_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module : blockmem_2p_rd_fifo
// Two-entry first-word-fall-through FIFO carrying read data plus a last flag.
// Rev    : 1.0
// ============================================================================
module blockmem_2p_rd_fifo
  import blockmem_2p_pkg::*;
#(
  parameter int G_DATAWIDTH = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire logic [G_DATAWIDTH-1:0] i_push_data,
  input  wire logic                   i_push_last,
  input  wire logic                   i_pop,
  output logic      [G_DATAWIDTH-1:0] o_head_data,
  output logic                        o_head_last,
  output logic      [1:0]             o_count,
  output logic                        o_empty
);

  logic [G_DATAWIDTH-1:0]    r_data [c_credit_depth];
  logic [c_credit_depth-1:0] r_last;
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;
  logic                      w_pop;

  // Popping an empty FIFO is ignored so the caller may drive tready freely.
  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_credit_depth; i++) begin
        r_data[i] <= '0;
      end
      r_last   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_last = r_last[r_rd_ptr];
  assign o_count     = r_count;
  assign o_empty     = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/blockmem_2p_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : blockmem_2p_stream_reader
// Streams cmd_len words from block-memory port B onto AXI-stream.
// Rev    : 1.0
// ============================================================================
module blockmem_2p_stream_reader
  import blockmem_2p_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024
) (
  input wire logic                     clk,
  input wire logic                     rst,
  blockmem_2p_stream_reader_if.master  bus
);

  localparam int                     G_ADDRWIDTH = $clog2(G_MEMDEPTH);
  localparam logic [G_ADDRWIDTH-1:0] c_last_addr = G_ADDRWIDTH'(G_MEMDEPTH - 1);
  localparam logic [G_ADDRWIDTH:0]   c_len_one   = (G_ADDRWIDTH + 1)'(1);

  state_t                 r_state;
  logic [G_ADDRWIDTH-1:0] r_addr;
  logic [G_ADDRWIDTH:0]   r_rem;
  logic                   r_inflight;
  logic                   r_inflight_last;
  logic                   r_busy;
  logic                   r_done;

  logic [G_DATAWIDTH-1:0] w_head_data;
  logic                   w_head_last;
  logic [1:0]             w_fifo_count;
  logic                   w_fifo_empty;
  logic [2:0]             w_credit_used;
  logic                   w_pop;
  logic                   w_has_credit;
  logic                   w_issue;
  logic                   w_last_read;

  assign w_pop         = !w_fifo_empty && bus.m_axis_tready;
  assign w_credit_used = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  // A slot freed by this cycle's pop can be reused at once, sustaining one beat per cycle.
  assign w_has_credit  = (w_credit_used < 3'(c_credit_depth)) ||
                         ((w_credit_used == 3'(c_credit_depth)) && w_pop);
  assign w_issue       = (r_state == ST_READ) && w_has_credit && !rst;
  assign w_last_read   = (r_rem == c_len_one);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_read;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr  <= bus.cmd_addr;
              r_rem   <= bus.cmd_len;
              r_busy  <= 1'b1;
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr <= (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (w_last_read) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // doutb is valid the cycle after enb, exactly when the in-flight flag is set.
  blockmem_2p_rd_fifo #(
    .G_DATAWIDTH (G_DATAWIDTH)
  ) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (bus.doutb),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign bus.cmd_ready     = (r_state == ST_IDLE) && !rst;
  assign bus.enb           = w_issue;
  assign bus.addrb         = r_addr;
  assign bus.m_axis_tdata  = w_head_data;
  assign bus.m_axis_tvalid = !w_fifo_empty;
  assign bus.m_axis_tlast  = w_head_last && !w_fifo_empty;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_blockmem_2p_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_blockmem_2p_stream_reader
// Randomized bench with a queue-based reference model of the stream reader.
// Rev    : 1.0
// ============================================================================
module tb_blockmem_2p_stream_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blockmem_2p_stream_reader_if #(.G_DATAWIDTH(DW), .G_MEMDEPTH(DEPTH)) bus_if ();

  blockmem_2p_stream_reader #(.G_DATAWIDTH(DW), .G_MEMDEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Port-B memory: registered read, data valid the cycle after enb.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) bus_if.doutb <= '0;
    else if (bus_if.enb) bus_if.doutb <= mem[bus_if.addrb];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state (updated only by the monitor).
  beat_t         exp_q[$];
  logic [DW-1:0] got_beats[$];
  bit            got_lasts[$];
  int            got_addrs[$];
  bit            exp_busy = 0, exp_done = 0;
  int            exp_addr = 0, reads_left = 0, outstanding = 0;
  int            cyc = 0, first_due = -1, beat_idx = 0;
  int            accept_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
  int            done_cnt = 0, acc_cnt = 0;
  bit            prev_stall = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;
  int            rmode = 0;

  always @(negedge clk) begin
    bit pop, nxt_busy, nxt_done;
    int nxt_out, len;
    cyc++;
    if (rst) begin
      chk(bus_if.cmd_ready == 1'b0, "rst_cmd_ready", bus_if.cmd_ready, 0);
      chk(bus_if.enb == 1'b0, "rst_enb", bus_if.enb, 0);
      exp_q.delete();
      exp_busy = 0; exp_done = 0; reads_left = 0; outstanding = 0;
      first_due = -1; prev_stall = 0;
    end else begin
      nxt_busy = exp_busy;
      nxt_done = 0;
      chk(bus_if.busy == exp_busy, "busy", bus_if.busy, exp_busy);
      chk(bus_if.done == exp_done, "done", bus_if.done, exp_done);
      chk(bus_if.cmd_ready == !exp_busy, "cmd_ready", bus_if.cmd_ready, !exp_busy);
      if (prev_stall) begin
        chk(bus_if.m_axis_tvalid == 1'b1, "stall_valid", bus_if.m_axis_tvalid, 1);
        chk(bus_if.m_axis_tdata == prev_data, "stall_data", bus_if.m_axis_tdata, prev_data);
        chk(bus_if.m_axis_tlast == prev_last, "stall_last", bus_if.m_axis_tlast, prev_last);
      end
      if (cyc == first_due)
        chk(bus_if.m_axis_tvalid == 1'b1, "first_beat_latency", bus_if.m_axis_tvalid, 1);
      pop = 0;
      if (bus_if.m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          chk(0, "spurious_beat", bus_if.m_axis_tdata, 0);
        end else begin
          chk(bus_if.m_axis_tdata == exp_q[0].data, "beat_data", bus_if.m_axis_tdata, exp_q[0].data);
          chk(bus_if.m_axis_tlast == exp_q[0].last, "beat_last", bus_if.m_axis_tlast, exp_q[0].last);
          if (bus_if.m_axis_tready) begin
            pop = 1;
            got_beats.push_back(bus_if.m_axis_tdata);
            got_lasts.push_back(bus_if.m_axis_tlast);
            if (beat_idx == 0) first_beat_cyc = cyc;
            beat_idx++;
            if (exp_q[0].last) begin
              nxt_busy = 0; nxt_done = 1; last_beat_cyc = cyc;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus_if.enb) begin
        got_addrs.push_back(int'(bus_if.addrb));
        if (reads_left == 0) begin
          chk(0, "extra_read", bus_if.addrb, 0);
        end else begin
          chk(int'(bus_if.addrb) == exp_addr, "addrb", bus_if.addrb, exp_addr);
          exp_addr = (exp_addr + 1) % DEPTH;
          reads_left--;
        end
      end
      nxt_out = outstanding + int'(bus_if.enb) - int'(pop);
      if (bus_if.enb) chk(nxt_out <= 2, "read_credit", nxt_out, 2);
      outstanding = nxt_out;
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        acc_cnt++;
        accept_cyc = cyc;
        len = int'(bus_if.cmd_len);
        if (len == 0) begin
          nxt_done = 1;
        end else begin
          nxt_busy   = 1;
          exp_addr   = int'(bus_if.cmd_addr);
          reads_left = len;
          beat_idx   = 0;
          first_due  = cyc + 3;  // accept edge + 2 cycles
          for (int i = 0; i < len; i++)
            exp_q.push_back('{mem[(int'(bus_if.cmd_addr) + i) % DEPTH], (i == len - 1)});
        end
      end
      if (bus_if.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus_if.m_axis_tvalid && !bus_if.m_axis_tready;
      prev_data  = bus_if.m_axis_tdata;
      prev_last  = bus_if.m_axis_tlast;
      exp_busy   = nxt_busy;
      exp_done   = nxt_done;
    end
  end

  // tready driver: 0 = always high, 1 = random, 2 = five low cycles then random.
  initial begin
    int lows, prev_mode;
    lows = 0;
    prev_mode = 0;
    bus_if.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 2 && prev_mode != 2) lows = 5;
      prev_mode = rmode;
      if (lows > 0) begin
        bus_if.m_axis_tready = 1'b0;
        lows--;
      end else if (rmode != 0) begin
        bus_if.m_axis_tready = 1'($urandom_range(0, 1));
      end else begin
        bus_if.m_axis_tready = 1'b1;
      end
    end
  end

  int mark_b = 0, mark_a = 0;

  task automatic send_cmd(input int addr, input int len);
    int start;
    start = acc_cnt;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = 10'(addr);
    bus_if.cmd_len   = 11'(len);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_cnt != start) break;
    end
    if (acc_cnt == start) chk(0, "cmd_accept_timeout", 0, 1);
    #1 bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start;
    start = done_cnt;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (done_cnt != start) break;
    end
    chk(done_cnt != start, "done_timeout", done_cnt - start, 1);
  endtask

  task automatic run_cmd(input int addr, input int len);
    mark_b = got_beats.size();
    mark_a = got_addrs.size();
    send_cmd(addr, len);
    wait_done(4 * len + 50);
  endtask

  initial begin
    int a, l, nl, d0;
    int exp_a[4];
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus_if.m_axis_tvalid == 1'b0, "rst_tvalid", bus_if.m_axis_tvalid, 0);
    chk(bus_if.m_axis_tlast == 1'b0, "rst_tlast", bus_if.m_axis_tlast, 0);
    chk(bus_if.busy == 1'b0, "rst_busy", bus_if.busy, 0);
    chk(bus_if.done == 1'b0, "rst_done", bus_if.done, 0);
    chk(bus_if.addrb == '0, "rst_addrb", bus_if.addrb, 0);
    chk(bus_if.m_axis_tdata == '0, "rst_tdata", bus_if.m_axis_tdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // addr 0x10, len 4, tready high.
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hCAFE_0000 + 32'(i);
    rmode = 0;
    run_cmd(16, 4);
    chk(got_beats.size() - mark_b == 4, "d1_count", got_beats.size() - mark_b, 4);
    for (int i = 0; i < 4; i++) begin
      chk(got_beats[mark_b + i] == 32'hCAFE_0000 + 32'(i), "d1_data", got_beats[mark_b + i], 32'hCAFE_0000 + i);
      chk(got_lasts[mark_b + i] == (i == 3), "d1_last", got_lasts[mark_b + i], i == 3);
    end
    chk(first_beat_cyc - accept_cyc == 3, "d1_latency", first_beat_cyc - accept_cyc, 3);
    chk(last_beat_cyc - first_beat_cyc == 3, "d1_throughput", last_beat_cyc - first_beat_cyc, 3);
    chk(done_cyc - last_beat_cyc == 1, "d1_done_delay", done_cyc - last_beat_cyc, 1);

    // Address wrap at the top of memory.
    run_cmd(1022, 4);
    exp_a = '{1022, 1023, 0, 1};
    chk(got_addrs.size() - mark_a == 4, "wrap_reads", got_addrs.size() - mark_a, 4);
    for (int i = 0; i < 4; i++)
      chk(got_addrs[mark_a + i] == exp_a[i], "wrap_addr", got_addrs[mark_a + i], exp_a[i]);
    chk(got_beats[mark_b + 2] == mem[0], "wrap_data", got_beats[mark_b + 2], mem[0]);

    // len 8 under backpressure, starting with five low cycles.
    rmode = 2;
    run_cmd(100, 8);
    chk(got_beats.size() - mark_b == 8, "bp_count", got_beats.size() - mark_b, 8);
    rmode = 0;

    // len 0: no reads, no beats, done one cycle after accept.
    run_cmd(5, 0);
    chk(done_cyc - accept_cyc == 1, "z_done_delay", done_cyc - accept_cyc, 1);
    chk(got_beats.size() - mark_b == 0, "z_beats", got_beats.size() - mark_b, 0);
    chk(got_addrs.size() - mark_a == 0, "z_reads", got_addrs.size() - mark_a, 0);

    // Reset after the third beat of a len 10 command.
    mark_b = got_beats.size();
    d0 = done_cnt;
    send_cmd(200, 10);
    for (int i = 0; i < 100; i++) begin
      if (got_beats.size() - mark_b >= 3) break;
      @(posedge clk);
    end
    chk(got_beats.size() - mark_b == 3, "mid_rst_beats", got_beats.size() - mark_b, 3);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(bus_if.m_axis_tvalid == 1'b0, "mid_rst_tvalid", bus_if.m_axis_tvalid, 0);
    chk(bus_if.busy == 1'b0, "mid_rst_busy", bus_if.busy, 0);
    repeat (6) @(posedge clk);
    chk(done_cnt == d0, "mid_rst_no_done", done_cnt - d0, 0);
    run_cmd(300, 2);
    chk(got_beats.size() - mark_b == 2, "post_rst_count", got_beats.size() - mark_b, 2);

    // Full-memory transfer.
    run_cmd(0, 1024);
    chk(got_beats.size() - mark_b == 1024, "full_count", got_beats.size() - mark_b, 1024);
    nl = 0;
    for (int i = 0; i < 1024; i++) nl += int'(got_lasts[mark_b + i]);
    chk(nl == 1, "full_lasts", nl, 1);
    chk(last_beat_cyc - first_beat_cyc == 1023, "full_throughput", last_beat_cyc - first_beat_cyc, 1023);

    // Random commands.
    for (int k = 0; k < 14; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 24);
      rmode = $urandom_range(0, 1);
      run_cmd(a, l);
      chk(got_beats.size() - mark_b == l, "rand_count", got_beats.size() - mark_b, l);
    end
    rmode = 0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
